// File: rtl/niosII_sys_pio_pkg.sv
// niosII_sys_pio_pkg: register word addresses and edge-type encodings shared by the PIO blocks
package niosII_sys_pio_pkg;
    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;
endpackage

// File: rtl/niosII_sys_pio_in_debounce.sv
// niosII_sys_pio_in_debounce: one input bit -- 2-flop synchronizer, debounce counter, debounced level and edge event
// Ports: clk, reset_n (async active-low), in_bit (async input), db (debounced level),
//        edge_evt (high in the cycle whose rising clk edge changes db in the selected direction)
module niosII_sys_pio_in_debounce
    import niosII_sys_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1,
    parameter int EDGE_TYPE       = EDGE_RISING
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic db,
    output logic edge_evt
);
    logic s1, s2, accept;
    logic [15:0] cnt;
    // accept is the condition under which db takes s2 at the coming edge, so the
    // event it qualifies lands on the same edge as the db change
    assign accept = (s2 != db) && (cnt == 16'(DEBOUNCE_CYCLES - 1));
    assign edge_evt = (EDGE_TYPE == EDGE_ANY)    ? accept :
                      (EDGE_TYPE == EDGE_RISING) ? accept && s2 : accept && !s2;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            db  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= in_bit;
            s2 <= s1;
            if (s2 == db) begin
                cnt <= '0;
            end else if (accept) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end
endmodule

// File: rtl/niosii_sys_pio_in.sv
// niosii_sys_pio_in: Avalon-MM input PIO with debounce, sticky edge capture and maskable level irq
// Ports: clk, reset_n (async active-low), address/chipselect/write_n/writedata (slave write side),
//        in_port (async board inputs), readdata (combinational, latency 0), irq (registered level)
// Map: 0 data (RO), 1 irqmask (RW), 2 reserved, 3 edgecapture (write-1-to-clear)
module niosii_sys_pio_in
    import niosII_sys_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1,
    parameter int EDGE_TYPE       = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] db, evt, irqmask, edgecap, clr;
    logic wr, unused_wd;
    assign wr = chipselect && !write_n;
    assign clr = (wr && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    assign unused_wd = ^writedata;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        niosII_sys_pio_in_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .EDGE_TYPE(EDGE_TYPE)
        ) u_db (
            .clk(clk),
            .reset_n(reset_n),
            .in_bit(in_port[i]),
            .db(db[i]),
            .edge_evt(evt[i])
        );
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
            edgecap <= '0;
            irq     <= 1'b0;
        end else begin
            if (wr && address == PIO_ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
            // OR-ing the event after the clear lets a new edge win over a same-cycle clear
            edgecap <= (edgecap & ~clr) | evt;
            irq     <= |(edgecap & irqmask);
        end
    end
    always_comb begin
        readdata = (address == PIO_ADDR_DATA)    ? 32'(db) :
                   (address == PIO_ADDR_IRQMASK) ? 32'(irqmask) :
                   (address == PIO_ADDR_EDGECAP) ? 32'(edgecap) : 32'd0;
    end
endmodule

// File: tb/tb_niosii_sys_pio_in.sv
// tb_niosii_sys_pio_in: scoreboard bench driving three PIO configurations from one shared bus
module tb_niosii_sys_pio_in;
    localparam int N = 3;
    int dc_cfg [N] = '{1, 4, 8};
    int et_cfg [N] = '{0, 2, 1};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [3:0]  in_port = 4'd0;
    logic [31:0] rd [N];
    logic        irq_o [N];

    always #5 clk = ~clk;

    niosii_sys_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(0)) u0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[0]), .irq(irq_o[0]));
    niosii_sys_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[1]), .irq(irq_o[1]));
    niosii_sys_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(1)) u2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[2]), .irq(irq_o[2]));

    // Reference model: db takes a new value once the last DEBOUNCE_CYCLES synchronized
    // samples all disagree with it; hist[t] is in_port as sampled t+1 edges ago.
    logic [3:0] m_db [N] = '{default: 4'd0};
    logic [3:0] m_mask [N] = '{default: 4'd0};
    logic [3:0] m_ec [N] = '{default: 4'd0};
    logic       m_irq [N] = '{default: 1'b0};
    logic [3:0] hist [10] = '{default: 4'd0};
    logic [3:0] m_evt, m_clr;
    logic       m_flip, m_nv, m_wr;

    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            for (int j = 0; j < N; j++) begin
                m_db[j] = 4'd0; m_mask[j] = 4'd0; m_ec[j] = 4'd0; m_irq[j] = 1'b0;
            end
            for (int t = 0; t < 10; t++) hist[t] = 4'd0;
        end else begin
            m_wr  = chipselect && !write_n;
            m_clr = (m_wr && address == 2'd3) ? writedata[3:0] : 4'd0;
            for (int j = 0; j < N; j++) begin
                m_evt = 4'd0;
                for (int b = 0; b < 4; b++) begin
                    m_flip = 1'b1;
                    for (int t = 1; t <= dc_cfg[j]; t++)
                        if (hist[t][b] == m_db[j][b]) m_flip = 1'b0;
                    if (m_flip) begin
                        m_nv = !m_db[j][b];
                        m_db[j][b] = m_nv;
                        m_evt[b] = (et_cfg[j] == 2) || (et_cfg[j] == 0 && m_nv) || (et_cfg[j] == 1 && !m_nv);
                    end
                end
                m_irq[j] = |(m_ec[j] & m_mask[j]);
                m_ec[j]  = (m_ec[j] & ~m_clr) | m_evt;
                if (m_wr && address == 2'd1) m_mask[j] = writedata[3:0];
            end
            for (int t = 9; t > 0; t--) hist[t] = hist[t-1];
            hist[0] = in_port;
        end
    end

    function automatic logic [31:0] exp_rd(int j, logic [1:0] a);
        return (a == 2'd0) ? {28'd0, m_db[j]} :
               (a == 2'd1) ? {28'd0, m_mask[j]} :
               (a == 2'd3) ? {28'd0, m_ec[j]} : 32'd0;
    endfunction

    typedef struct {
        int          j;
        logic [1:0]  a;
        logic [31:0] rd;
        logic        irq;
    } exp_t;
    exp_t sbq [$];
    exp_t cur;
    int checks = 0;
    int errors = 0;

    // Monitor: the DUT presents readdata/irq every cycle; compare once they have settled.
    initial forever begin
        @(negedge clk);
        #2;
        while (sbq.size() > 0) begin
            cur = sbq.pop_front();
            checks++;
            if (rd[cur.j] !== cur.rd) begin
                errors++;
                $display("FAIL readdata u%0d addr%0d t=%0t got %h expected %h", cur.j, cur.a, $time, rd[cur.j], cur.rd);
            end
            checks++;
            if (irq_o[cur.j] !== cur.irq) begin
                errors++;
                $display("FAIL irq u%0d t=%0t got %b expected %b", cur.j, $time, irq_o[cur.j], cur.irq);
            end
        end
    end

    task automatic cyc(input logic [3:0] inp, input logic rn, input logic cs,
                       input logic wn, input logic [1:0] a, input logic [31:0] wd);
        exp_t e;
        @(negedge clk);
        in_port = inp; reset_n = rn; chipselect = cs; write_n = wn; address = a; writedata = wd;
        #1;
        for (int j = 0; j < N; j++) begin
            e.j = j; e.a = a; e.rd = exp_rd(j, a); e.irq = m_irq[j];
            sbq.push_back(e);
        end
    endtask

    task automatic rd_(input logic [3:0] inp, input logic [1:0] a);
        cyc(inp, 1'b1, 1'b1, 1'b1, a, 32'd0);
    endtask

    task automatic wr_(input logic [3:0] inp, input logic [1:0] a, input logic [31:0] d);
        cyc(inp, 1'b1, 1'b1, 1'b0, a, d);
    endtask

    task automatic hold(input logic [3:0] inp, input int n);
        for (int i = 0; i < n; i++) rd_(inp, 2'(i));
    endtask

    task automatic settle_clear(input logic [3:0] inp);
        hold(inp, 12);
        wr_(inp, 2'd3, 32'hF);
        rd_(inp, 2'd3);
    endtask

    initial begin
        // reset held, then activity, then reset asserted mid-activity with toggling inputs
        for (int i = 0; i < 3; i++) cyc(4'd0, 1'b0, 1'b0, 1'b1, 2'(i), 32'd0);
        wr_(4'd0, 2'd1, 32'hF);
        for (int i = 0; i < 20; i++) rd_(4'($urandom), 2'(i));
        for (int i = 0; i < 6; i++) cyc(4'($urandom), 1'b0, 1'b1, 1'b1, 2'(i), 32'd0);
        hold(4'd0, 12);

        // rising capture on bit 0, then unmask to raise irq
        hold(4'h1, 12);
        wr_(4'h1, 2'd1, 32'h1);
        hold(4'h1, 4);

        // clear takes effect, irq drops
        wr_(4'h1, 2'd3, 32'h1);
        rd_(4'h1, 2'd3);
        rd_(4'h1, 2'd3);

        // new bit-0 rising edge lands on the same edge as its clear in u0
        settle_clear(4'h0);
        rd_(4'h1, 2'd3);
        rd_(4'h1, 2'd3);
        wr_(4'h1, 2'd3, 32'h1);
        hold(4'h1, 4);

        // 3-cycle glitch on bit 2, then a held level
        settle_clear(4'h0);
        wr_(4'h0, 2'd1, 32'hF);
        rd_(4'h4, 2'd0); rd_(4'h4, 2'd3); rd_(4'h4, 2'd0);
        hold(4'h0, 12);
        hold(4'h4, 10);

        // falling edge on bit 3 across the three edge types
        settle_clear(4'h8);
        hold(4'h0, 12);

        // reset five cycles into a bit-0 transition, input back to 0
        settle_clear(4'h0);
        hold(4'h1, 5);
        cyc(4'h0, 1'b0, 1'b0, 1'b1, 2'd0, 32'd0);
        cyc(4'h0, 1'b0, 1'b0, 1'b1, 2'd3, 32'd0);
        hold(4'h0, 14);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) in_port = 4'($urandom);
            case ($urandom_range(7))
                0: wr_(in_port, 2'($urandom), $urandom);
                1: cyc(in_port, 1'b1, 1'b0, 1'b0, 2'($urandom), $urandom);
                2: if ($urandom_range(15) == 0) cyc(in_port, 1'b0, 1'b1, 1'b1, 2'd0, 32'd0);
                   else rd_(in_port, 2'd3);
                default: rd_(in_port, 2'($urandom));
            endcase
        end
        hold(in_port, 2);
        @(negedge clk);
        #5;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/niosii_sys_pio_in.md
# niosII_sys_pio_in

Avalon-MM slave input port: the read-side counterpart of the single-bit output PIO registers in the Nios II system. Samples `WIDTH` asynchronous board inputs (buttons, LCD busy line, status pins), synchronizes and debounces them, and latches selected edges into a sticky edge-capture register. Raises a maskable level interrupt to the Nios II. Sits on the system interconnect beside the output PIOs and uses the same 2-bit word address map style.

## Interface
Parameters:
- `WIDTH`, 4: number of input bits, 1..32.
- `DEBOUNCE_CYCLES`, 1: consecutive cycles a new synchronized value must hold before it is accepted, 1..65535. A value of 1 means no debounce.
- `EDGE_TYPE`, 0: edge type captured. 0 = rising, 1 = falling, 2 = any.

Ports:
- `clk`  in  1  system clock. This is the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  word address.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `in_port`  in  WIDTH  asynchronous external inputs.
- `readdata`  out  32  read data. Combinational from `address`, read latency 0.
- `irq`  out  1  registered level interrupt.

## Operation
Register map (unused upper bits read 0):
- Address 0, `data`: read-only. Returns the debounced value `db[WIDTH-1:0]`. Writes are ignored.
- Address 1, `irqmask`: read/write, `WIDTH` bits.
- Address 2: reserved. Reads 0; writes are ignored.
- Address 3, `edgecapture`: read, and write-1-to-clear per bit.

Write qualification:
- A write takes effect when `chipselect && !write_n` is true at a `clk` rising edge.

Per-bit pipeline:
- Synchronizer: `in_port` → `s1` → `s2`.
- Debounce counter `cnt`:
  - If `s2 == db`: `cnt` <= 0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `db` <= `s2` and `cnt` <= 0.
  - Else: `cnt` <= `cnt` + 1.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles at `s2` never reaches `db`.

Edge detection:
- An edge event is raised on the same clock edge on which `db` changes:
  - rising: 0→1
  - falling: 1→0
  - any: either direction
- The event sets the corresponding `edgecapture` bit.
- Set has priority over a simultaneous write-1-to-clear of the same bit; the bit stays 1.

Interrupt:
- `irq` <= `|(edgecapture & irqmask)`. Both operands are the current register values, so `irq` is registered one cycle after the term becomes true.

Reset (asynchronous):
- `s1`, `s2`, `db`, `cnt`, `irqmask`, `edgecapture` and `irq` all clear to 0.
- `readdata` reads 0 at every address.
- An input held high through reset produces a rising-edge capture after release. This is intended: software clears `edgecapture` before unmasking.
- Reset mid-debounce discards the count. No capture is produced for the aborted transition.

## Timing
Take `in_port` bit as stable at its new value before rising edge k.
- `s2` holds the new value after edge k+1.
- `db` and `edgecapture` update at edge k+1+`DEBOUNCE_CYCLES`. For `DEBOUNCE_CYCLES`=1 this is k+2.
- `irq` asserts one edge later, provided the mask bit is set.
- Writing `irqmask` at edge m: `irq` reflects the new mask at edge m+1.
- Clearing `edgecapture` at edge m: `irq` deasserts at edge m+1, unless another captured bit is still masked in.
- Reads are combinational and reflect register state as of the most recent edge.

## Structure
- Shared package `niosII_sys_pio_pkg` holds:
  - address constants `PIO_ADDR_DATA`, `PIO_ADDR_IRQMASK`, `PIO_ADDR_EDGECAP`
  - edge-type encodings `EDGE_RISING`, `EDGE_FALLING`, `EDGE_ANY`
- Sub-module `niosII_sys_pio_in_debounce`: one bit, containing the synchronizer, counter, `db` and the edge-event output. The top instantiates it `WIDTH` times with a generate loop.
- The top holds the register file, read mux and `irq` flop.

## Test plan
- Reset: assert `reset_n`=0 mid-activity with inputs toggling → `irq`=0 and `readdata`=0 at addresses 0–3; after release with `in_port`=0, everything stays 0.
- Rising capture, `DEBOUNCE_CYCLES`=1, `EDGE_TYPE`=0, `WIDTH`=4: `in_port` 0→1 on bit 0 before edge k →
  - address 0 reads 0x1 after k+2
  - address 3 reads 0x1
  - `irq`=0
  - writing `irqmask`=0x1 → `irq`=1 one edge later
- Debounce, `DEBOUNCE_CYCLES`=4:
  - bit 2 high pulse of 3 cycles → `data` and `edgecapture` stay 0
  - high level of ≥4 cycles → `data`=0x4 at edge k+5
- Clear priority: with bit 0 captured, write 0x1 to address 3 → bit cleared and `irq` drops next edge. Repeat with a new bit-0 edge landing on the same edge as the clear → bit remains 1.
- Edge type: `EDGE_TYPE`=2 → 1→0 on bit 3 sets 0x8. `EDGE_TYPE`=0 → the same 1→0 leaves `edgecapture` at 0.
- Reset mid-debounce: `DEBOUNCE_CYCLES`=8, pulse `reset_n` low 5 cycles into a transition, then return input to 0 → no capture and `data`=0.
